dispatch_unit: RTL and testbench

DISPATCH_UNIT -- requirements
Module: dispatch_unit

---
 rtl/dispatch_pkg.sv | 77 +++++++
 rtl/dispatch_iq.sv | 56 +++++
 rtl/dispatch_unit.sv | 111 +++++++++++
 tb/tb_dispatch_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types, constants and the instruction decoder for the dispatch stage.
// Decodes an RV32-style subset: OP, OP-IMM, LOAD, STORE, BRANCH.
package dispatch_pkg;

  localparam int REG_ADDRESS_SIZE = 5;
  localparam int INSTR_SIZE       = 32;

  localparam logic [2:0] UNIT_ALU = 3'b001;
  localparam logic [2:0] UNIT_MUL = 3'b010;
  localparam logic [2:0] UNIT_MEM = 3'b100;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [INSTR_SIZE-1:0] instr;
    logic [INSTR_SIZE-1:0] pc;
  } iq_entry_t;

  typedef struct packed {
    logic [2:0]                  unit;
    logic [REG_ADDRESS_SIZE-1:0] src1;
    logic [REG_ADDRESS_SIZE-1:0] src2;
    logic [REG_ADDRESS_SIZE-1:0] dest;
    logic [31:0]                 imm;
    logic [31:0]                 bimm;
    logic                        immEn;
    logic                        store;
    logic                        branch;
    logic                        write;
    logic                        op;
  } decode_t;

  function automatic decode_t decode(input logic [INSTR_SIZE-1:0] instr);
    decode_t d;
    d.unit   = UNIT_ALU;
    d.src1   = instr[19:15];
    d.src2   = instr[24:20];
    d.dest   = instr[11:7];
    d.imm    = {{20{instr[31]}}, instr[31:20]};
    d.bimm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    d.immEn  = 1'b0;
    d.store  = 1'b0;
    d.branch = 1'b0;
    d.write  = 1'b0;
    d.op     = instr[30];
    // Unknown opcodes behave as an ALU op with no second register source.
    case (instr[6:0])
      OPC_OP: begin
        d.write = 1'b1;
        if (instr[31:25] == 7'b0000001) d.unit = UNIT_MUL;
      end
      OPC_OPIMM: begin
        d.immEn = 1'b1;
        d.write = 1'b1;
      end
      OPC_LOAD: begin
        d.unit  = UNIT_MEM;
        d.immEn = 1'b1;
        d.write = 1'b1;
      end
      OPC_STORE: begin
        d.unit  = UNIT_MEM;
        d.immEn = 1'b1;
        d.store = 1'b1;
        d.imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: d.branch = 1'b1;
      default:    d.immEn  = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dispatch_iq.sv
// Instruction queue: power-of-two FIFO of {instr,pc} with flush and
// asynchronous active-low reset; no fall-through from enqueue to head.
module dispatch_iq
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_push,
  input  iq_entry_t i_data,
  input  logic      i_pop,
  input  logic      i_flush,
  output logic      o_ready,
  output logic      o_valid,
  output iq_entry_t o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_pushFire;
  logic             w_popFire;

  assign o_ready    = (r_count < CNT_W'(DEPTH));
  assign o_valid    = (r_count != '0);
  assign o_head     = r_mem[r_rdPtr];
  assign w_pushFire = i_push & o_ready & ~i_flush;
  assign w_popFire  = i_pop & o_valid & ~i_flush;

  always_ff @(posedge clk) begin
    if (w_pushFire) r_mem[r_wrPtr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushFire) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_popFire)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_pushFire) - CNT_W'(w_popFire);
    end
  end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: queues fetched instructions, decodes the head, resolves
// operands and issues in order. DISPATCH_WB_BYPASS_EN enables writeback forwarding.
module dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int REG_SIZE     = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int ID_SIZE      = 3,
  parameter int IQ_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDRESS_SIZE-1:0]       in_instr,
  input  logic [ADDRESS_SIZE-1:0]       in_pc,
  output logic [2*REG_ADDRESS_SIZE-1:0] rf_addr,
  input  logic [2*REG_SIZE-1:0]         rf_data,
  input  logic [1:0]                    dep_hit,
  input  logic [1:0]                    dep_ready,
  input  logic [2*REG_SIZE-1:0]         dep_value,
  input  logic                          wb_we,
  input  logic [REG_ADDRESS_SIZE-1:0]   wb_addr,
  input  logic [REG_SIZE-1:0]           wb_value,
  input  logic [2:0]                    unit_stall,
  input  logic                          rob_stall,
  input  logic                          flush,
  output logic                          iss_valid,
  output logic [2:0]                    iss_unit,
  output logic [REG_SIZE-1:0]           iss_op1,
  output logic [REG_SIZE-1:0]           iss_op2,
  output logic [ADDRESS_SIZE-1:0]       iss_bimm,
  output logic [REG_ADDRESS_SIZE-1:0]   iss_dest,
  output logic [2:0]                    iss_ctrl,
  output logic [ID_SIZE-1:0]            iss_tag
);

  iq_entry_t                        w_enq;
  iq_entry_t                        w_head;
  logic                             w_headValid;
  decode_t                          w_dec;
  logic [1:0][REG_ADDRESS_SIZE-1:0] w_src;
  logic [1:0][REG_SIZE-1:0]         w_rf;
  logic [1:0][REG_SIZE-1:0]         w_dep;
  logic [1:0][REG_SIZE-1:0]         w_res;
  logic [REG_SIZE-1:0]              w_imm;
  logic                             w_need2;
  logic                             w_block;
  logic [ID_SIZE-1:0]               r_tag;
  logic                             w_unused;

  assign w_enq = '{instr: INSTR_SIZE'(in_instr), pc: INSTR_SIZE'(in_pc)};

  dispatch_iq #(.DEPTH(IQ_DEPTH)) u_iq (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid),
    .i_data  (w_enq),
    .i_pop   (iss_valid),
    .i_flush (flush),
    .o_ready (in_ready),
    .o_valid (w_headValid),
    .o_head  (w_head)
  );

  assign w_dec   = decode(w_head.instr);
  assign w_src   = {w_dec.src2, w_dec.src1};
  assign rf_addr = w_src;
  assign w_rf    = rf_data;
  assign w_dep   = dep_value;
  assign w_imm   = REG_SIZE'(w_dec.imm);

  // Ready in-flight producers win over writeback, which wins over the bank.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_res[i] = w_rf[i];
`ifdef DISPATCH_WB_BYPASS_EN
      if (wb_we && (wb_addr == w_src[i]) && (w_src[i] != '0)) w_res[i] = wb_value;
`endif
      if (dep_hit[i] && dep_ready[i]) w_res[i] = w_dep[i];
    end
  end

  // Stores carry src2 as data, so they still wait on it despite using an immediate.
  assign w_need2 = ~w_dec.immEn | w_dec.store;
  assign w_block = rob_stall
                 | (|(unit_stall & w_dec.unit))
                 | (dep_hit[0] & ~dep_ready[0])
                 | (w_need2 & dep_hit[1] & ~dep_ready[1]);

  assign iss_valid = w_headValid & ~w_block & ~flush;
  assign iss_unit  = w_headValid ? w_dec.unit : 3'b000;
  assign iss_op1   = w_res[0];
  assign iss_op2   = ((w_dec.unit == UNIT_MEM) || w_dec.immEn) ? w_imm : w_res[1];
  assign iss_bimm  = w_dec.store ? ADDRESS_SIZE'(w_res[1]) : ADDRESS_SIZE'(w_dec.bimm);
  assign iss_dest  = w_dec.dest;
  assign iss_ctrl  = {w_dec.branch, w_dec.write, w_dec.op};
  assign iss_tag   = r_tag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_tag <= '0;
    else if (iss_valid) r_tag <= r_tag + ID_SIZE'(1);
  end

`ifdef DISPATCH_WB_BYPASS_EN
  assign w_unused = ^w_head.pc;
`else
  assign w_unused = ^{w_head.pc, wb_we, wb_addr, wb_value};
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// Self-checking bench for dispatch_unit: a vector table of single-instruction
// issue cases plus directed multi-cycle sequences (fill, stall, flush, reset).
module tb_dispatch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [9:0]  rf_addr;
  logic [63:0] rf_data;
  logic [1:0]  dep_hit;
  logic [1:0]  dep_ready;
  logic [63:0] dep_value;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_value;
  logic [2:0]  unit_stall;
  logic        rob_stall;
  logic        flush;
  logic        iss_valid;
  logic [2:0]  iss_unit;
  logic [31:0] iss_op1;
  logic [31:0] iss_op2;
  logic [31:0] iss_bimm;
  logic [4:0]  iss_dest;
  logic [2:0]  iss_ctrl;
  logic [2:0]  iss_tag;

  dispatch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .dep_hit    (dep_hit),
    .dep_ready  (dep_ready),
    .dep_value  (dep_value),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_value   (wb_value),
    .unit_stall (unit_stall),
    .rob_stall  (rob_stall),
    .flush      (flush),
    .iss_valid  (iss_valid),
    .iss_unit   (iss_unit),
    .iss_op1    (iss_op1),
    .iss_op2    (iss_op2),
    .iss_bimm   (iss_bimm),
    .iss_dest   (iss_dest),
    .iss_ctrl   (iss_ctrl),
    .iss_tag    (iss_tag)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADD_I  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] MUL_I  = 32'h027302B3;  // mul  x5,x6,x7
  localparam logic [31:0] ADDI_I = 32'hFF808213;  // addi x4,x1,-8
  localparam logic [31:0] LW_I   = 32'h00C12403;  // lw   x8,12(x2)
  localparam logic [31:0] SW_I   = 32'h00912A23;  // sw   x9,20(x2)
  localparam logic [31:0] BEQ_I  = 32'h00208863;  // beq  x1,x2,+16

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rf1;
    logic [31:0] rf0;
    logic [1:0]  hit;
    logic [1:0]  rdy;
    logic [31:0] dv1;
    logic [31:0] dv0;
    logic [2:0]  ustall;
    logic        rob;
    logic        fl;
    logic        expValid;
    logic [2:0]  expUnit;
    logic [31:0] expOp1;
    logic [31:0] expOp2;
    logic        chkBimm;
    logic [31:0] expBimm;
    logic [4:0]  expDest;
    logic [2:0]  expCtrl;
    logic [9:0]  expAddr;
  } vec_t;

  vec_t       vecs [13];
  int         testsRun  = 0;
  int         failCount = 0;
  logic [2:0] expTag;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearSide();
    rf_data    = '0;
    dep_hit    = '0;
    dep_ready  = '0;
    dep_value  = '0;
    wb_we      = 1'b0;
    wb_addr    = '0;
    wb_value   = '0;
    unit_stall = '0;
    rob_stall  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic enqueue(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = in_pc + 32'd4;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issueOne();
    enqueue(ADD_I);
    #1;
    checkOutput("issue_valid", iss_valid, 1);
    checkOutput("issue_tag", iss_tag, expTag);
    tick();
    expTag++;
  endtask

  // One instruction into an empty queue; side inputs applied while it is head.
  task automatic applyStimulus(input vec_t v);
    enqueue(v.instr);
    rf_data    = {v.rf1, v.rf0};
    dep_hit    = v.hit;
    dep_ready  = v.rdy;
    dep_value  = {v.dv1, v.dv0};
    unit_stall = v.ustall;
    rob_stall  = v.rob;
    flush      = v.fl;
    #1;
    checkOutput($sformatf("%s.valid", v.name), iss_valid, v.expValid);
    checkOutput($sformatf("%s.unit", v.name), iss_unit, v.expUnit);
    checkOutput($sformatf("%s.op1", v.name), iss_op1, v.expOp1);
    checkOutput($sformatf("%s.op2", v.name), iss_op2, v.expOp2);
    checkOutput($sformatf("%s.dest", v.name), iss_dest, v.expDest);
    checkOutput($sformatf("%s.ctrl", v.name), iss_ctrl, v.expCtrl);
    checkOutput($sformatf("%s.rfaddr", v.name), rf_addr, v.expAddr);
    checkOutput($sformatf("%s.tag", v.name), iss_tag, expTag);
    if (v.chkBimm) checkOutput($sformatf("%s.bimm", v.name), iss_bimm, v.expBimm);
    tick();
    if (v.expValid) begin
      expTag++;
    end else if (!v.fl) begin
      flush = 1'b1;
      tick();
    end
    clearSide();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int accepted;
    //                 name            instr   rf1       rf0       hit    rdy    dv1       dv0            ustall  rob   fl    val   unit    op1             op2            cb    bimm      dest   ctrl    addr
    vecs[0]  = '{"add",           ADD_I,  32'h22,   32'h11,   2'b00, 2'b00, 32'h0,    32'h0,         3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 32'h11,         32'h22,        1'b0, 32'h0,    5'd3,  3'b010, 10'h041};
    vecs[1]  = '{"mul_fwd",       MUL_I,  32'h7,    32'h6,    2'b01, 2'b01, 32'h0,    32'hAAAA,      3'b000, 1'b0, 1'b0, 1'b1, 3'b010, 32'hAAAA,       32'h7,         1'b0, 32'h0,    5'd5,  3'b010, 10'h0E6};
    vecs[2]  = '{"addi_dep2",     ADDI_I, 32'h55,   32'h100,  2'b10, 2'b00, 32'h0,    32'h0,         3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 32'h100,        32'hFFFFFFF8,  1'b0, 32'h0,    5'd4,  3'b011, 10'h301};
    vecs[3]  = '{"lw",            LW_I,   32'h0,    32'h1000, 2'b00, 2'b00, 32'h0,    32'h0,         3'b000, 1'b0, 1'b0, 1'b1, 3'b100, 32'h1000,       32'hC,         1'b0, 32'h0,    5'd8,  3'b010, 10'h182};
    vecs[4]  = '{"sw",            SW_I,   32'h1234, 32'h2000, 2'b00, 2'b00, 32'h0,    32'h0,         3'b000, 1'b0, 1'b0, 1'b1, 3'b100, 32'h2000,       32'h14,        1'b1, 32'h1234, 5'd20, 3'b000, 10'h122};
    vecs[5]  = '{"beq",           BEQ_I,  32'h5,    32'h5,    2'b00, 2'b00, 32'h0,    32'h0,         3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 32'h5,          32'h5,         1'b1, 32'h10,   5'd16, 3'b100, 10'h041};
    vecs[6]  = '{"beq_wait2",     BEQ_I,  32'h5,    32'h5,    2'b10, 2'b00, 32'h0,    32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 32'h5,          32'h5,         1'b1, 32'h10,   5'd16, 3'b100, 10'h041};
    vecs[7]  = '{"add_rob",       ADD_I,  32'h22,   32'h11,   2'b00, 2'b00, 32'h0,    32'h0,         3'b000, 1'b1, 1'b0, 1'b0, 3'b001, 32'h11,         32'h22,        1'b0, 32'h0,    5'd3,  3'b010, 10'h041};
    vecs[8]  = '{"mul_stall",     MUL_I,  32'h7,    32'h6,    2'b00, 2'b00, 32'h0,    32'h0,         3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 32'h6,          32'h7,         1'b0, 32'h0,    5'd5,  3'b010, 10'h0E6};
    vecs[9]  = '{"mul_alu_busy",  MUL_I,  32'h7,    32'h6,    2'b00, 2'b00, 32'h0,    32'h0,         3'b001, 1'b0, 1'b0, 1'b1, 3'b010, 32'h6,          32'h7,         1'b0, 32'h0,    5'd5,  3'b010, 10'h0E6};
    vecs[10] = '{"add_flush",     ADD_I,  32'h22,   32'h11,   2'b00, 2'b00, 32'h0,    32'h0,         3'b000, 1'b0, 1'b1, 1'b0, 3'b001, 32'h11,         32'h22,        1'b0, 32'h0,    5'd3,  3'b010, 10'h041};
    vecs[11] = '{"add_both_fwd",  ADD_I,  32'h22,   32'h11,   2'b11, 2'b11, 32'hBBBB, 32'hCCCC,      3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 32'hCCCC,       32'hBBBB,      1'b0, 32'h0,    5'd3,  3'b010, 10'h041};
    vecs[12] = '{"addi_wait1",    ADDI_I, 32'h55,   32'h100,  2'b01, 2'b00, 32'h0,    32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 32'h100,        32'hFFFFFFF8,  1'b0, 32'h0,    5'd4,  3'b011, 10'h301};

    reset    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc    = 32'h1000;
    clearSide();
    expTag   = '0;

    #12;
    checkOutput("reset_valid", iss_valid, 0);
    checkOutput("reset_ready", in_ready, 1);
    checkOutput("reset_unit", iss_unit, 0);
    checkOutput("reset_tag", iss_tag, 0);
    reset = 1'b1;
    tick();

    // Four back-to-back ADDs issue on consecutive cycles with tags 0..3.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instr = ADD_I;
      #1;
      if (k == 0) begin
        checkOutput("b2b_no_fallthrough", iss_valid, 0);
      end else begin
        checkOutput($sformatf("b2b_valid%0d", k - 1), iss_valid, 1);
        checkOutput($sformatf("b2b_tag%0d", k - 1), iss_tag, expTag);
        expTag++;
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checkOutput("b2b_valid3", iss_valid, 1);
    checkOutput("b2b_tag3", iss_tag, expTag);
    expTag++;
    tick();
    checkOutput("b2b_drained", iss_valid, 0);

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

    // ALU busy: only IQ_DEPTH of five offers are taken; nothing issues.
    unit_stall = 3'b001;
    accepted   = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_instr = ADD_I;
      #1;
      checkOutput($sformatf("full_ready%0d", k), in_ready, (k < 4) ? 1 : 0);
      checkOutput($sformatf("full_stalled%0d", k), iss_valid, 0);
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("full_accepted", accepted, 4);
    unit_stall = 3'b000;
    #1;
    checkOutput("full_issue_ready", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("full_drain_valid%0d", k), iss_valid, 1);
      checkOutput($sformatf("full_drain_tag%0d", k), iss_tag, expTag);
      tick();
      expTag++;
    end
    checkOutput("full_empty", iss_valid, 0);

    // src1 producer in flight for three cycles, then forwarded.
    enqueue(ADD_I);
    dep_hit   = 2'b01;
    dep_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("dep_wait%0d", k), iss_valid, 0);
      tick();
    end
    dep_ready = 2'b01;
    dep_value = {32'h0, 32'hDEAD_BEEF};
    #1;
    checkOutput("dep_issue", iss_valid, 1);
    checkOutput("dep_op1", iss_op1, 32'hDEADBEEF);
    checkOutput("dep_tag", iss_tag, expTag);
    tick();
    expTag++;
    clearSide();

    // Flush with tag 5 and three queued entries, then tag wrap 7 -> 0.
    while (expTag != 3'd5) issueOne();
    rob_stall = 1'b1;
    for (int k = 0; k < 3; k++) enqueue(ADD_I);
    in_valid = 1'b1;
    in_instr = ADD_I;
    flush    = 1'b1;
    #1;
    checkOutput("flush_hold_valid", iss_valid, 0);
    checkOutput("flush_hold_unit", iss_unit, 3'b001);
    tick();
    in_valid  = 1'b0;
    flush     = 1'b0;
    rob_stall = 1'b0;
    #1;
    checkOutput("flush_empty_valid", iss_valid, 0);
    checkOutput("flush_empty_unit", iss_unit, 0);
    checkOutput("flush_ready", in_ready, 1);
    checkOutput("flush_tag_kept", iss_tag, 3'd5);
    issueOne();
    issueOne();
    issueOne();
    checkOutput("wrap_expect_zero", expTag, 3'd0);
    issueOne();

    // Asynchronous reset mid-operation discards queue and tag.
    rob_stall = 1'b1;
    enqueue(ADD_I);
    enqueue(ADD_I);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_valid", iss_valid, 0);
    checkOutput("midreset_ready", in_ready, 1);
    checkOutput("midreset_tag", iss_tag, 0);
    checkOutput("midreset_unit", iss_unit, 0);
    #2;
    reset     = 1'b1;
    rob_stall = 1'b0;
    expTag    = '0;
    tick();

    // Writeback forwarding onto src1 = x3, and never onto x0.
    enqueue(32'h000180B3);
    wb_we    = 1'b1;
    wb_addr  = 5'd3;
    wb_value = 32'hA5;
    rf_data  = '0;
    #1;
`ifdef DISPATCH_WB_BYPASS_EN
    checkOutput("wb_fwd_op1", iss_op1, 32'hA5);
`else
    checkOutput("wb_fwd_op1", iss_op1, 32'h0);
`endif
    checkOutput("wb_fwd_tag", iss_tag, expTag);
    tick();
    expTag++;
    enqueue(32'h000000B3);
    wb_we    = 1'b1;
    wb_addr  = 5'd0;
    wb_value = 32'h99;
    rf_data  = {32'h0, 32'h77};
    #1;
    checkOutput("wb_x0_op1", iss_op1, 32'h77);
    checkOutput("wb_x0_valid", iss_valid, 1);
    tick();
    clearSide();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
